// File: rtl/hd_pkg.sv
// Shared definitions for the disk controller: opcodes, FSM states and default sizes.
package hd_pkg;

  localparam int NUM_SETORES_PAD    = 64;
  localparam int PALAVRAS_SETOR_PAD = 16;
  localparam int LATENCIA_PAD       = 8;

  localparam logic [1:0] HD_NADA      = 2'd0;
  localparam logic [1:0] HD_LER       = 2'd1;
  localparam logic [1:0] HD_GRAVAR    = 2'd2;
  localparam logic [1:0] HD_RESERVADO = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    LEITURA,
    ESCRITA,
    FIM
  } estado_t;

  // Counter width that stays at least one bit wide for tiny ranges.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hd_armazenamento.sv
// Single-port synchronous RAM backing the disk store: write enable, registered read.
module hd_armazenamento #(
  parameter int PROFUNDIDADE = 1024,
  parameter int LARG_END     = 10
) (
  input  logic                clock,
  input  logic                we,
  input  logic [LARG_END-1:0] endereco,
  input  logic [31:0]         dado_escrita,
  output logic [31:0]         dado_lido
);

  logic [31:0] mem [PROFUNDIDADE];

  // NOTE: no reset here on purpose -- the disk contents must survive reset,
  // and a resettable array would not map onto block RAM anyway.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[endereco] <= dado_escrita;
    end
    dado_lido <= mem[endereco];
  end

endmodule

// File: rtl/controle_hd.sv
// Sector-oriented disk controller: word writes and full-sector streamed reads.
// Build option: define CONTROLE_HD_SEEK_EN to insert the LATENCIA-cycle SEEK phase.
module controle_hd
  import hd_pkg::*;
#(
  parameter int NUM_SETORES    = NUM_SETORES_PAD,
  parameter int PALAVRAS_SETOR = PALAVRAS_SETOR_PAD,
  parameter int LATENCIA       = LATENCIA_PAD
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [1:0]                        OpHD,
  input  logic [$clog2(NUM_SETORES)-1:0]    setor,
  input  logic [$clog2(PALAVRAS_SETOR)-1:0] palavra,
  input  logic [31:0]                       dadoEscrita,
  output logic [31:0]                       dadoLido,
  output logic [$clog2(PALAVRAS_SETOR)-1:0] endLido,
  output logic                              validoLido,
  output logic                              pronto,
  output logic                              ocupado
);

  localparam int SW = $clog2(NUM_SETORES);
  localparam int PW = $clog2(PALAVRAS_SETOR);
  localparam logic [PW-1:0] ULTIMA = PW'(PALAVRAS_SETOR - 1);

  estado_t       estado, proximo;
  logic [1:0]    op_r;
  logic [SW-1:0] setor_r;
  logic [PW-1:0] palavra_r;
  logic [31:0]   dado_r;
  logic [PW-1:0] cnt_palavra;
  logic          fim_leitura;
  logic          aceita;
  logic          le_agora;
  logic          we;
  logic [31:0]   q_ram;

`ifdef CONTROLE_HD_SEEK_EN
  localparam int CW = largura(LATENCIA);
  logic [CW-1:0] cnt_seek;
`endif

  assign aceita   = (estado == IDLE) && ((OpHD == HD_LER) || (OpHD == HD_GRAVAR));
  // One extra LEITURA cycle with no read issued lets the last word drain
  // before FIM, so pronto never overlaps validoLido.
  assign le_agora = (estado == LEITURA) && !fim_leitura;
  assign we       = (estado == ESCRITA);
  assign ocupado  = (estado != IDLE);
  assign dadoLido = validoLido ? q_ram : 32'd0;

  always_comb begin
    // NOTE: default first so every path assigns proximo and no latch is inferred.
    proximo = estado;
    unique case (estado)
      IDLE: begin
        if (aceita) begin
`ifdef CONTROLE_HD_SEEK_EN
          proximo = SEEK;
`else
          proximo = (OpHD == HD_LER) ? LEITURA : ESCRITA;
`endif
        end
      end
      SEEK: begin
`ifdef CONTROLE_HD_SEEK_EN
        if (cnt_seek == '0) begin
          proximo = (op_r == HD_LER) ? LEITURA : ESCRITA;
        end
`else
        proximo = IDLE;
`endif
      end
      LEITURA: if (fim_leitura) proximo = FIM;
      ESCRITA: proximo = FIM;
      FIM:     proximo = IDLE;
      default: proximo = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= IDLE;
      op_r        <= HD_NADA;
      setor_r     <= '0;
      palavra_r   <= '0;
      dado_r      <= '0;
      cnt_palavra <= '0;
      fim_leitura <= 1'b0;
      validoLido  <= 1'b0;
      endLido     <= '0;
      pronto      <= 1'b0;
    end else begin
      estado     <= proximo;
      pronto     <= (proximo == FIM);
      validoLido <= le_agora;
      if (le_agora) begin
        endLido <= cnt_palavra;
      end
      if (aceita) begin
        op_r        <= OpHD;
        setor_r     <= setor;
        palavra_r   <= palavra;
        dado_r      <= dadoEscrita;
        cnt_palavra <= '0;
        fim_leitura <= 1'b0;
      end else if (le_agora) begin
        if (cnt_palavra == ULTIMA) begin
          fim_leitura <= 1'b1;
        end else begin
          cnt_palavra <= cnt_palavra + 1'b1;
        end
      end
    end
  end

`ifdef CONTROLE_HD_SEEK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_seek <= '0;
    end else if (aceita) begin
      cnt_seek <= CW'(LATENCIA - 1);
    end else if ((estado == SEEK) && (cnt_seek != '0)) begin
      cnt_seek <= cnt_seek - 1'b1;
    end
  end
`endif

  hd_armazenamento #(
    .PROFUNDIDADE (NUM_SETORES * PALAVRAS_SETOR),
    .LARG_END     (SW + PW)
  ) u_armazenamento (
    .clock        (clock),
    .we           (we),
    .endereco     ({setor_r, (estado == ESCRITA) ? palavra_r : cnt_palavra}),
    .dado_escrita (dado_r),
    .dado_lido    (q_ram)
  );

endmodule

// File: tb/tb_controle_hd.sv
// Directed bench for controle_hd with a read-data scoreboard and latency checks.
module tb_controle_hd;
  import hd_pkg::*;

  localparam int NS  = 64;
  localparam int PS  = 16;
  localparam int LAT = 8;
  localparam int SW  = $clog2(NS);
  localparam int PW  = $clog2(PS);
`ifdef CONTROLE_HD_SEEK_EN
  localparam int LAT_EFF = LAT;
`else
  localparam int LAT_EFF = 0;
`endif
  // Latency = rising edges from the acceptance edge through the edge ending the pronto cycle.
  localparam int LAT_GRAVAR = LAT_EFF + 2;
  localparam int LAT_LER    = LAT_EFF + PS + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    OpHD;
  logic [SW-1:0] setor;
  logic [PW-1:0] palavra;
  logic [31:0]   dadoEscrita;
  logic [31:0]   dadoLido;
  logic [PW-1:0] endLido;
  logic          validoLido;
  logic          pronto;
  logic          ocupado;

  typedef struct {
    int          idx;
    logic [31:0] dado;
  } esperado_t;

  esperado_t   fila[$];
  logic [31:0] modelo [NS*PS];
  int          total = 0;
  int          bad   = 0;
  int          lat, primeiro, nvalid;

  controle_hd #(.NUM_SETORES(NS), .PALAVRAS_SETOR(PS), .LATENCIA(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .OpHD        (OpHD),
    .setor       (setor),
    .palavra     (palavra),
    .dadoEscrita (dadoEscrita),
    .dadoLido    (dadoLido),
    .endLido     (endLido),
    .validoLido  (validoLido),
    .pronto      (pronto),
    .ocupado     (ocupado)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, scrambles the address/data inputs after acceptance,
  // optionally holds OpHD until pronto, and scoreboards every streamed word.
  task automatic executa(input logic [1:0] op, input int s, input int p, input logic [31:0] d,
                         input bit segura_op, output int lat_o, output int prim_o, output int nv_o);
    int k;
    esperado_t e;
    @(negedge clock);
    OpHD = op; setor = SW'(s); palavra = PW'(p); dadoEscrita = d;
    if (op == HD_LER) begin
      for (int i = 0; i < PS; i++) fila.push_back('{i, modelo[s*PS+i]});
    end else if (op == HD_GRAVAR) begin
      modelo[s*PS+p] = d;
    end
    @(posedge clock);
    #1;
    if (!segura_op) OpHD = HD_NADA;
    setor = SW'($urandom); palavra = PW'($urandom); dadoEscrita = $urandom;
    k = 0; lat_o = -1; prim_o = -1; nv_o = 0;
    while (lat_o < 0 && k < 300) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      if (k == 1) check("ocupado_apos_aceite", ocupado, 1);
      check("pronto_e_valido", pronto & validoLido, 0);
      if (validoLido) begin
        nv_o++;
        if (prim_o < 0) prim_o = k;
        if (fila.size() == 0) begin
          check("valido_extra", 1, 0);
        end else begin
          e = fila.pop_front();
          check("endLido", 32'(endLido), 32'(e.idx));
          if (!$isunknown(e.dado)) check("dadoLido", dadoLido, e.dado);
        end
      end
      if (pronto) begin
        lat_o = k + 1;
        OpHD = HD_NADA;
      end
    end
    if (lat_o < 0) check("timeout_pronto", 1, 0);
    @(posedge clock);
    #1;
    check("pronto_um_ciclo", pronto, 0);
    check("idle_apos_fim", ocupado, 0);
  endtask

  initial begin
    for (int i = 0; i < NS*PS; i++) modelo[i] = 'x;
    reset = 1'b1; OpHD = HD_NADA; setor = '0; palavra = '0; dadoEscrita = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_pronto", pronto, 0);
    check("reset_valido", validoLido, 0);
    check("reset_ocupado", ocupado, 0);
    check("reset_dado", dadoLido, 0);
    check("reset_end", 32'(endLido), 0);
    @(negedge clock);
    reset = 1'b0;

    repeat (10) begin
      @(negedge clock);
      check("idle_pronto", pronto, 0);
      check("idle_valido", validoLido, 0);
      check("idle_ocupado", ocupado, 0);
    end

    for (int i = 0; i < PS; i++) begin
      executa(HD_GRAVAR, 5, i, $urandom, 0, lat, primeiro, nvalid);
      check("lat_preenche", lat, LAT_GRAVAR);
    end

    executa(HD_GRAVAR, 5, 3, 32'hCAFE0001, 0, lat, primeiro, nvalid);
    check("lat_gravar", lat, LAT_GRAVAR);

    executa(HD_LER, 5, 0, 32'h0, 0, lat, primeiro, nvalid);
    check("lat_ler", lat, LAT_LER);
    check("primeiro_valido", primeiro, LAT_EFF + 1);
    check("num_validos", nvalid, PS);
    check("fila_vazia", fila.size(), 0);

    // OpHD held through the operation, dropped on pronto, re-issued next cycle.
    executa(HD_GRAVAR, 7, 9, 32'h1234ABCD, 1, lat, primeiro, nvalid);
    check("lat_segura1", lat, LAT_GRAVAR);
    executa(HD_GRAVAR, 7, 10, 32'h0BADF00D, 1, lat, primeiro, nvalid);
    check("lat_segura2", lat, LAT_GRAVAR);
    repeat (5) begin
      @(negedge clock);
      check("sem_pronto_extra", pronto, 0);
    end
    executa(HD_LER, 7, 0, 32'h0, 1, lat, primeiro, nvalid);
    check("lat_ler7", lat, LAT_LER);
    check("num_validos7", nvalid, PS);

    // Reset during the 4th LEITURA cycle.
    @(negedge clock);
    OpHD = HD_LER; setor = SW'(5);
    @(posedge clock);
    #1 OpHD = HD_NADA;
    repeat (LAT_EFF + 3) @(posedge clock);
    @(negedge clock);
    check("meio_leitura_valido", validoLido, 1);
    check("meio_leitura_end", 32'(endLido), 2);
    reset = 1'b1;
    #1;
    check("abort_valido", validoLido, 0);
    check("abort_pronto", pronto, 0);
    check("abort_ocupado", ocupado, 0);
    check("abort_dado", dadoLido, 0);
    check("abort_end", 32'(endLido), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (LAT_LER + 5) begin
      @(negedge clock);
      check("abort_sem_pronto", pronto, 0);
    end

    executa(HD_LER, 5, 0, 32'h0, 0, lat, primeiro, nvalid);
    check("lat_releitura", lat, LAT_LER);
    check("num_validos_rel", nvalid, PS);

    executa(HD_GRAVAR, 0, 0, 32'h5A5A0F0F, 0, lat, primeiro, nvalid);
    check("lat_gravar_s0", lat, LAT_GRAVAR);

    @(negedge clock);
    OpHD = HD_RESERVADO; setor = '0; palavra = PW'(1); dadoEscrita = 32'hFFFFFFFF;
    repeat (6) begin
      @(negedge clock);
      check("reservado_ocupado", ocupado, 0);
      check("reservado_pronto", pronto, 0);
    end
    OpHD = HD_NADA;

    executa(HD_LER, 0, 0, 32'h0, 0, lat, primeiro, nvalid);
    check("lat_ler_s0", lat, LAT_LER);
    check("fila_vazia_fim", fila.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_hd.md
CONTROLE_HD -- requirements
Module: controle_hd

Interface
REQ-001 Parameter NUM_SETORES, default 64; number of sectors in the disk store.
REQ-002 Parameter PALAVRAS_SETOR, default 16; 32-bit words per sector, power of two.
REQ-003 Parameter LATENCIA, default 8; seek delay in clock cycles, >=1.
REQ-004 Ports:
- clock  in  1  Rising-edge clock, the single clock domain.
- reset  in  1  Asynchronous, active-high reset.
- OpHD  in  2  Request: 0 none, 1 read sector, 2 write word, 3 reserved.
- setor  in  log2(NUM_SETORES)  Sector address.
- palavra  in  log2(PALAVRAS_SETOR)  Word offset, used by writes.
- dadoEscrita  in  32  Write data.
- dadoLido  out  32  Read stream data.
- endLido  out  log2(PALAVRAS_SETOR)  Word index of dadoLido.
- validoLido  out  1  dadoLido/endLido valid this cycle.
- pronto  out  1  Operation complete.
- ocupado  out  1  FSM not in IDLE.

Function
REQ-005 FSM states: IDLE, SEEK, LEITURA, ESCRITA, FIM.
REQ-006 In IDLE, OpHD=1 or OpHD=2 is accepted on a rising edge; setor, palavra, dadoEscrita and the opcode are registered on that edge.
REQ-007 OpHD=0 or OpHD=3 in IDLE leaves the FSM in IDLE with no side effects.
REQ-008 After acceptance: IDLE->SEEK; seek counter loads LATENCIA-1; SEEK lasts exactly LATENCIA cycles.
REQ-009 SEEK exits to LEITURA for a read and to ESCRITA for a write.
REQ-010 ESCRITA lasts one cycle: stores the latched dadoEscrita at (setor, palavra), then goes to FIM.
REQ-011 LEITURA streams words 0..PALAVRAS_SETOR-1 of the latched sector in ascending order, one per cycle, with no gaps.
REQ-012 Each streamed word asserts validoLido for one cycle, with endLido equal to the word index.
REQ-013 The first validoLido occurs one cycle after LEITURA is entered (synchronous storage read latency of 1).
REQ-014 LEITURA goes to FIM on the cycle the last word (index PALAVRAS_SETOR-1) is presented; the word counter does not wrap past it.
REQ-015 FIM asserts pronto for exactly one cycle, then returns to IDLE.
REQ-016 OpHD is ignored while in FIM, so a requester that drops OpHD combinationally on pronto causes no re-trigger.
REQ-017 A new request is accepted no earlier than the cycle after FIM.
REQ-018 OpHD changes outside IDLE are ignored; the latched operation completes.
REQ-019 Total latency from acceptance edge to pronto:
- write: LATENCIA+2 cycles.
- read: LATENCIA+PALAVRAS_SETOR+2 cycles.
REQ-020 ocupado=1 in every state except IDLE.
REQ-021 pronto and validoLido are registered outputs and are never high in the same cycle.

Reset
REQ-022 Reset asserted forces, asynchronously: IDLE; pronto=0, validoLido=0, ocupado=0, dadoLido=0, endLido=0; all counters and latches cleared.
REQ-023 Reset mid-operation aborts the operation with no pronto pulse.
REQ-024 Reset mid-ESCRITA leaves the addressed word either fully old or fully new.
REQ-025 Reset never clears stored disk contents.

Configuration
REQ-026 Macro CONTROLE_HD_SEEK_EN defined: the SEEK state and seek counter are compiled in, as in REQ-008/009.
REQ-027 Macro CONTROLE_HD_SEEK_EN undefined: SEEK and its counter are compiled out; acceptance goes directly to LEITURA/ESCRITA.
REQ-028 Without the macro, latencies are 2 cycles (write) and PALAVRAS_SETOR+2 cycles (read); LATENCIA is unused.

Structure
REQ-029 Shared package hd_pkg holds:
- OpHD encodings (HD_NADA=0, HD_LER=1, HD_GRAVAR=2).
- FSM state enumeration.
- Defaults for NUM_SETORES, PALAVRAS_SETOR and LATENCIA.
REQ-030 The storage array is one sub-module, hd_armazenamento:
- Single-port synchronous RAM of NUM_SETORES*PALAVRAS_SETOR x 32.
- Write enable; registered read; address = {setor, palavra}.

Verification
REQ-031 Reset then idle 10 cycles -> pronto=0, validoLido=0, ocupado=0 throughout.
REQ-032 Write, macro defined, LATENCIA=8: OpHD=2, setor=5, palavra=3, dadoEscrita=32'hCAFE0001 -> pronto single pulse exactly 10 cycles after acceptance.
REQ-033 Read back after REQ-032: OpHD=1, setor=5 -> 16 consecutive validoLido pulses, endLido 0..15; word 3 = 32'hCAFE0001; pronto one cycle after word 15.
REQ-034 OpHD dropped combinationally on pronto, then OpHD=2 issued the next cycle -> exactly one pronto per request; the second request is accepted in IDLE.
REQ-035 Reset asserted on the 4th LEITURA cycle -> outputs zero immediately, no pronto; re-read of sector 5 still returns 32'hCAFE0001 at word 3.
REQ-036 Macro undefined: write to setor=0, palavra=0 -> pronto 2 cycles after acceptance; OpHD=3 in IDLE -> FSM stays in IDLE.
